sdram_bus_responder: RTL and testbench



---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_bus_responder_if.sv | 24 ++
 rtl/sdram_bus_responder_bram_be32.sv | 37 +++
 rtl/sdram_bus_responder.sv | 182 ++++++++++++++++++
 tb/tb_sdram_bus_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request/ack/rdvalid bus and its responder.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } sdram_resp_state_e;

    // Replace only the byte lanes selected by be; other lanes keep old_word.
    function automatic logic [SDRAM_DATA_W-1:0] be_merge(
        input logic [SDRAM_DATA_W-1:0] old_word,
        input logic [SDRAM_DATA_W-1:0] new_word,
        input logic [SDRAM_BE_W-1:0]   be
    );
        logic [SDRAM_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < SDRAM_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sdram_bus_responder_if.sv
// SDRAM request/ack/rdvalid bus between a cache (master) and memory (slave).
interface sdram_bus_responder_if;
    import sdram_pkg::*;

    logic                    sdram_request;
    logic [SDRAM_ADDR_W-1:0] sdram_addr;
    logic                    sdram_write;
    logic [SDRAM_BE_W-1:0]   sdram_byte_enable;
    logic [SDRAM_DATA_W-1:0] sdram_wdata;
    logic                    sdram_ack;
    logic [SDRAM_DATA_W-1:0] sdram_rdata;
    logic                    sdram_rdvalid;

    modport master (
        output sdram_request, sdram_addr, sdram_write, sdram_byte_enable, sdram_wdata,
        input  sdram_ack, sdram_rdata, sdram_rdvalid
    );

    modport slave (
        input  sdram_request, sdram_addr, sdram_write, sdram_byte_enable, sdram_wdata,
        output sdram_ack, sdram_rdata, sdram_rdvalid
    );

endinterface

// File: rtl/sdram_bus_responder_bram_be32.sv
// Single-port 32-bit block RAM with per-byte write enables and a registered read port.
module bram_be32
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS = 14
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_re,
    input  logic [SDRAM_BE_W-1:0]   i_we,
    input  logic [ADDR_BITS-1:0]    i_addr,
    input  logic [SDRAM_DATA_W-1:0] i_wdata,
    output logic [SDRAM_DATA_W-1:0] o_rdata
);

    logic [SDRAM_DATA_W-1:0] r_mem [0:(1<<ADDR_BITS)-1];
    logic [SDRAM_DATA_W-1:0] r_q;

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (i_we != 4'b0000) begin
            r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_we);
        end
    end

    // Registered read; holds its value between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 32'h0000_0000;
        end else if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/sdram_bus_responder.sv
// Memory end of the SDRAM bus: wait states, one-cycle ack, byte writes, in-order read return.
// Optional protocol checker: define SDRAM_RESP_CHECK_EN.
module sdram_bus_responder
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS    = 14,
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    sdram_bus_responder_if.slave  bus
);

    sdram_resp_state_e       r_state, w_state_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt;
    logic                    r_ack;
    logic [ADDR_BITS-1:0]    r_lat_idx;
    logic                    r_lat_write;
    logic [SDRAM_BE_W-1:0]   r_lat_be;
    logic [SDRAM_DATA_W-1:0] r_lat_wdata;
    logic [READ_LATENCY-1:0] r_vld;
    logic                    w_rd_fire;
    logic [SDRAM_BE_W-1:0]   w_wr_be;
    logic [SDRAM_DATA_W-1:0] w_ram_q;
    logic [SDRAM_DATA_W-1:0] w_rdata;

    // Next-state logic; the request is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.sdram_request) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ACK;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ACK;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counter and registered ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (w_state_nxt == ACK);
        end
    end

    // Capture the request on the sampling edge so later input changes are irrelevant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat_idx   <= '0;
            r_lat_write <= 1'b0;
            r_lat_be    <= 4'b0000;
            r_lat_wdata <= 32'h0000_0000;
        end else if ((r_state == IDLE) && bus.sdram_request) begin
            r_lat_idx   <= bus.sdram_addr[ADDR_BITS+1:2];
            r_lat_write <= bus.sdram_write;
            r_lat_be    <= bus.sdram_byte_enable;
            r_lat_wdata <= bus.sdram_wdata;
        end
    end

    assign w_rd_fire = (r_state == ACK) && !r_lat_write && !reset;
    assign w_wr_be   = ((r_state == ACK) && r_lat_write && !reset) ? r_lat_be : 4'b0000;

    bram_be32 #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .i_re    (w_rd_fire),
        .i_we    (w_wr_be),
        .i_addr  (r_lat_idx),
        .i_wdata (r_lat_wdata),
        .o_rdata (w_ram_q)
    );

    // Read-return valid shift; the RAM output register is data stage 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_rl1
        assign w_rdata = w_ram_q;
    end else begin : g_rln
        logic [SDRAM_DATA_W-1:0] r_dat [1:READ_LATENCY-1];

        // Data moves only with a valid so the output holds between returns.
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 1; i < READ_LATENCY; i++) begin
                    r_dat[i] <= 32'h0000_0000;
                end
            end else begin
                if (r_vld[0]) begin
                    r_dat[1] <= w_ram_q;
                end
                for (int i = 2; i < READ_LATENCY; i++) begin
                    if (r_vld[i-1]) begin
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end
        end

        assign w_rdata = r_dat[READ_LATENCY-1];
    end

    assign bus.sdram_ack     = r_ack;
    assign bus.sdram_rdvalid = r_vld[READ_LATENCY-1];
    assign bus.sdram_rdata   = w_rdata;

`ifdef SDRAM_RESP_CHECK_EN
    logic                    r_chk_err;
    logic [SDRAM_ADDR_W-1:0] r_chk_addr;
    logic                    r_chk_write;
    logic [SDRAM_BE_W-1:0]   r_chk_be;
    logic [SDRAM_DATA_W-1:0] r_chk_wdata;

    // Simulation-only protocol watch with a sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chk_err   <= 1'b0;
            r_chk_addr  <= '0;
            r_chk_write <= 1'b0;
            r_chk_be    <= 4'b0000;
            r_chk_wdata <= 32'h0000_0000;
        end else begin
            if ((r_state == IDLE) && bus.sdram_request) begin
                r_chk_addr  <= bus.sdram_addr;
                r_chk_write <= bus.sdram_write;
                r_chk_be    <= bus.sdram_byte_enable;
                r_chk_wdata <= bus.sdram_wdata;
                if ((bus.sdram_addr >> (ADDR_BITS + 2)) != '0) begin
                    $display("sdram_bus_responder: error: address %h aliases", bus.sdram_addr);
                    r_chk_err <= 1'b1;
                end
            end
            if (r_state == WAIT) begin
                if (!bus.sdram_request) begin
                    $display("sdram_bus_responder: error: request dropped before ack");
                    r_chk_err <= 1'b1;
                end
                if ((bus.sdram_addr != r_chk_addr) || (bus.sdram_write != r_chk_write) ||
                    (bus.sdram_byte_enable != r_chk_be) || (bus.sdram_wdata != r_chk_wdata)) begin
                    $display("sdram_bus_responder: error: request fields changed before ack");
                    r_chk_err <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_bus_responder.sv
// Self-checking bench: vector table, randomized traffic against a word-level memory model,
// and hand sequences for reset abandonment and pipelined reads.
module tb_sdram_bus_responder;
    import sdram_pkg::*;

    localparam int AB = 14;
    localparam int WS = 2;
    localparam int RL = 3;

    logic clock   = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   acks_a  = 0;
    int   acks_exp = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sdram_bus_responder_if bus_a();
    sdram_bus_responder_if bus_b();

    sdram_bus_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS), .READ_LATENCY(RL)) u_dut_a (
        .clock (clock), .reset (reset_a), .bus (bus_a)
    );
    sdram_bus_responder #(.ADDR_BITS(AB), .WAIT_STATES(0), .READ_LATENCY(8)) u_dut_b (
        .clock (clock), .reset (reset_b), .bus (bus_b)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [25:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t        expq[$];
    logic [31:0] model [int];
    vec_t        tbl [12];
    int          rv_cyc[$];
    logic [31:0] rv_dat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Read returns on DUT A must match the expected queue in order and cycle.
    always @(negedge clock) begin
        exp_t e;
        if (bus_a.sdram_rdvalid) begin
            if (expq.size() == 0) begin
                check("rdvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check("rd_cycle", cyc, e.cyc);
                check("rd_data", bus_a.sdram_rdata, e.data);
            end
        end
        if (bus_a.sdram_ack) acks_a++;
    end

    // One transaction on DUT A; returns just after the edge that closes the ack cycle.
    task automatic do_req(input logic [25:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] d, input bit use_exp, input logic [31:0] exp_d,
                          input bit chg, input logic [25:0] a2);
        int   t, n, idx;
        exp_t e;
        bus_a.sdram_request     = 1'b1;
        bus_a.sdram_addr        = a;
        bus_a.sdram_write       = w;
        bus_a.sdram_byte_enable = be;
        bus_a.sdram_wdata       = d;
        t   = cyc;
        idx = int'(a[AB+1:2]);
        if (chg) begin
            @(posedge clock); #1;
            bus_a.sdram_addr = a2;
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus_a.sdram_ack && n < 50);
        if (!bus_a.sdram_ack) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_cycle", cyc, t + 1 + WS);
            acks_exp++;
            if (w) begin
                model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, d, be);
            end else begin
                e.data = use_exp ? exp_d : model[idx];
                e.cyc  = cyc + RL;
                expq.push_back(e);
            end
        end
        @(posedge clock); #1;
        bus_a.sdram_request = 1'b0;
        bus_a.sdram_write   = 1'b0;
    endtask

    // One transaction on DUT B (no wait states); reports the ack cycle.
    task automatic b_req(input logic [25:0] a, input logic w, input logic [31:0] d, output int ac);
        int t, n;
        bus_b.sdram_request     = 1'b1;
        bus_b.sdram_addr        = a;
        bus_b.sdram_write       = w;
        bus_b.sdram_byte_enable = 4'hF;
        bus_b.sdram_wdata       = d;
        t = cyc;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus_b.sdram_ack && n < 20);
        if (!bus_b.sdram_ack) begin
            check("b_ack_timeout", 32'd0, 32'd1);
            ac = -100;
        end else begin
            check("b_ack_cycle", cyc, t + 1);
            ac = cyc;
        end
        @(posedge clock); #1;
        bus_b.sdram_request = 1'b0;
        bus_b.sdram_write   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: reached cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int ac0, ac1, ac2, k, gap, acks_before, cnt;
        logic [3:0] be;
        logic [31:0] d;

        tbl[0]  = '{26'h0000100, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{26'h0000100, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{26'h0000200, 1'b1, 4'hF, 32'h11223344, 32'h0};
        tbl[3]  = '{26'h0000200, 1'b1, 4'h5, 32'hAABBCCDD, 32'h0};
        tbl[4]  = '{26'h0000200, 1'b0, 4'hF, 32'h0,        32'h11BB33DD};
        tbl[5]  = '{26'h0000300, 1'b1, 4'hF, 32'h55555555, 32'h0};
        tbl[6]  = '{26'h0000300, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0};
        tbl[7]  = '{26'h0000300, 1'b0, 4'hF, 32'h0,        32'h55555555};
        tbl[8]  = '{26'h0010100, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[9]  = '{26'h000FFFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[10] = '{26'h000FFFC, 1'b0, 4'hF, 32'h0,        32'hCAFEF00D};
        tbl[11] = '{26'h0000101, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};

        // Request held during reset must be ignored.
        bus_a.sdram_request = 1'b1; bus_a.sdram_addr = 26'h100; bus_a.sdram_write = 1'b0;
        bus_a.sdram_byte_enable = 4'hF; bus_a.sdram_wdata = 32'h0;
        bus_b.sdram_request = 1'b0; bus_b.sdram_addr = 26'h0; bus_b.sdram_write = 1'b0;
        bus_b.sdram_byte_enable = 4'hF; bus_b.sdram_wdata = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        bus_a.sdram_request = 1'b0;
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clock);
        check("reset_ack", {31'b0, bus_a.sdram_ack}, 32'd0);
        check("reset_rdvalid", {31'b0, bus_a.sdram_rdvalid}, 32'd0);
        check("reset_rdata", bus_a.sdram_rdata, 32'h0);
`ifdef SDRAM_RESP_CHECK_EN
        check("chk_flag_clear", {31'b0, u_dut_a.r_chk_err}, 32'd0);
`endif
        @(posedge clock); #1;

        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i].addr, tbl[i].wr, tbl[i].be, tbl[i].wdata, !tbl[i].wr, tbl[i].exp, 1'b0, 26'h0);
        end

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_req(26'h400 + 26'(4*i), 1'b1, 4'hF, d, 1'b0, 32'h0, 1'b0, 26'h0);
        end
        for (int i = 0; i < 80; i++) begin
            k   = $urandom_range(0, 15);
            gap = $urandom_range(0, 2);
            be  = 4'($urandom);
            d   = $urandom;
            repeat (gap) begin @(posedge clock); #1; end
            do_req(26'h400 + 26'(4*k), 1'($urandom_range(0, 1)), be, d, 1'b0, 32'h0, 1'b0, 26'h0);
        end

        // Address changed mid-request: the latched address must still be used.
        do_req(26'h100, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 26'h200);
`ifdef SDRAM_RESP_CHECK_EN
        check("chk_flag_set", {31'b0, u_dut_a.r_chk_err}, 32'd1);
`endif

        // Reset during the WAIT cycle abandons the read.
        repeat (RL + 2) begin @(posedge clock); #1; end
        acks_before = acks_a;
        bus_a.sdram_request = 1'b1; bus_a.sdram_addr = 26'h100; bus_a.sdram_write = 1'b0;
        @(posedge clock); #1;
        reset_a = 1'b1;
        bus_a.sdram_request = 1'b0;
        @(posedge clock); #1;
        reset_a = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        check("reset_wait_no_ack", acks_a, acks_before);
        do_req(26'h200, 1'b0, 4'hF, 32'h0, 1'b1, 32'h11BB33DD, 1'b0, 26'h0);

        // DUT B: back-to-back reads with several in flight.
        b_req(26'h0, 1'b1, 32'd1, ac0);
        b_req(26'h4, 1'b1, 32'd2, ac0);
        b_req(26'h8, 1'b1, 32'd3, ac0);
        fork
            begin
                for (int j = 0; j < 30; j++) begin
                    @(negedge clock);
                    if (bus_b.sdram_rdvalid) begin
                        rv_cyc.push_back(cyc);
                        rv_dat.push_back(bus_b.sdram_rdata);
                    end
                end
            end
            begin
                b_req(26'h0, 1'b0, 32'h0, ac0);
                b_req(26'h4, 1'b0, 32'h0, ac1);
                b_req(26'h8, 1'b0, 32'h0, ac2);
            end
        join
        check("b_rdvalid_count", rv_cyc.size(), 32'd3);
        if (rv_cyc.size() == 3) begin
            check("b_rd0_data", rv_dat[0], 32'd1);
            check("b_rd1_data", rv_dat[1], 32'd2);
            check("b_rd2_data", rv_dat[2], 32'd3);
            check("b_rd0_cycle", rv_cyc[0], ac0 + 8);
            check("b_rd1_cycle", rv_cyc[1], ac1 + 8);
            check("b_rd2_cycle", rv_cyc[2], ac2 + 8);
        end

        // DUT B: reset with two reads in flight flushes both.
        b_req(26'h0, 1'b0, 32'h0, ac0);
        b_req(26'h4, 1'b0, 32'h0, ac1);
        reset_b = 1'b1;
        @(posedge clock); #1;
        reset_b = 1'b0;
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clock);
            if (bus_b.sdram_rdvalid || bus_b.sdram_ack) cnt++;
        end
        check("b_reset_flush", cnt, 32'd0);
        @(posedge clock); #1;
        b_req(26'h8, 1'b0, 32'h0, ac2);
        cnt = 0;
        while (!bus_b.sdram_rdvalid && cnt < 12) begin
            @(negedge clock);
            cnt++;
        end
        check("b_retained_valid", {31'b0, bus_b.sdram_rdvalid}, 32'd1);
        check("b_retained_data", bus_b.sdram_rdata, 32'd3);
        check("b_retained_cycle", cyc, ac2 + 8);

        repeat (RL + 3) begin @(posedge clock); #1; end
        check("exp_queue_empty", expq.size(), 32'd0);
        check("ack_count", acks_a, acks_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
